// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of one synchronous single-port RAM.
// Ports: clk/rst; p0_*/p1_* req/we/addr/wdata in, ack/rdata out; mem_* out; mem_rdata in; gnt out.
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    gnt
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          p0_ack_q, p0_ack_d;
  logic          p1_ack_q, p1_ack_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic [DW-1:0] resp_data;
  logic          pick0;

  // RAM data is itself a register output, valid only in the RESP cycle,
  // so it is steered straight to the owner while ack is high and then held.
  assign resp_data = mem_we_q ? '0 : mem_rdata;

  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p0_rdata  = p0_ack_q ? resp_data : p0_rdata_q;
  assign p1_rdata  = p1_ack_q ? resp_data : p1_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign gnt       = gnt_q;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    // last_q=1 means port 1 was granted last, so port 0 wins a tie
    pick0       = p0_req && (!p1_req || last_q);
    unique case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_d  = ACCESS;
          mem_en_d = 1'b1;
          last_d   = !pick0;
          if (pick0) begin
            gnt_d       = 2'b01;
            mem_we_d    = p0_we;
            mem_addr_d  = p0_addr;
            mem_wdata_d = p0_wdata;
          end else begin
            gnt_d       = 2'b10;
            mem_we_d    = p1_we;
            mem_addr_d  = p1_addr;
            mem_wdata_d = p1_wdata;
          end
        end
      end
      ACCESS: begin
        state_d  = RESP;
        p0_ack_d = gnt_q[0];
        p1_ack_d = gnt_q[1];
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        if (gnt_q[0]) p0_rdata_d = resp_data;
        if (gnt_q[1]) p1_rdata_d = resp_data;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      last_q      <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous RAM model.
// Checks latency, round-robin, write/read data path, reset abort, latching.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  gnt;

  logic [15:0] mem [0:65535];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .gnt(gnt)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    mem[16'h0010] = 16'h8005;
    mem[16'h0004] = 16'h1234;
    mem[16'h0008] = 16'h5678;
    mem_rdata = 16'h0000;
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    tick();
    tick();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_en", mem_en, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wdata", mem_wdata, 16'h0000);
    chk("rst_acks", {p0_ack, p1_ack}, 2'b00);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 32'h0);

    // p0 read of 0x0010
    rst = 1'b0;
    p0_req = 1; p0_we = 0; p0_addr = 16'h0010;
    tick();
    chk("rd_en", mem_en, 1'b1);
    chk("rd_addr", mem_addr, 16'h0010);
    chk("rd_we", mem_we, 1'b0);
    chk("rd_gnt", gnt, 2'b01);
    chk("rd_ack_early", p0_ack, 1'b0);
    tick();
    p0_req = 0;
    chk("rd_ack", p0_ack, 1'b1);
    chk("rd_data", p0_rdata, 16'h8005);
    chk("rd_p1ack", p1_ack, 1'b0);
    chk("rd_en_off", mem_en, 1'b0);
    chk("rd_gnt_resp", gnt, 2'b01);
    tick();
    chk("rd_ack_one", p0_ack, 1'b0);
    chk("rd_gnt_idle", gnt, 2'b00);
    chk("rd_hold", p0_rdata, 16'h8005);
    chk("rd_addr_hold", mem_addr, 16'h0010);

    // p1 write 0x0200 <= 0xBEEF, then p0 reads it back
    p1_req = 1; p1_we = 1; p1_addr = 16'h0200; p1_wdata = 16'hBEEF;
    tick();
    chk("wr_en", mem_en, 1'b1);
    chk("wr_we", mem_we, 1'b1);
    chk("wr_wdata", mem_wdata, 16'hBEEF);
    chk("wr_addr", mem_addr, 16'h0200);
    chk("wr_gnt", gnt, 2'b10);
    tick();
    p1_req = 0;
    chk("wr_ack", p1_ack, 1'b1);
    chk("wr_rdata0", p1_rdata, 16'h0000);
    chk("wr_p0ack", p0_ack, 1'b0);
    chk("wr_p0hold", p0_rdata, 16'h8005);
    tick();
    p0_req = 1; p0_we = 0; p0_addr = 16'h0200;
    tick();
    chk("rb_gnt", gnt, 2'b01);
    tick();
    p0_req = 0;
    chk("rb_ack", p0_ack, 1'b1);
    chk("rb_data", p0_rdata, 16'hBEEF);
    tick();

    // both requesting continuously from reset: p0,p1,p0,p1
    rst = 1'b1;
    p0_req = 1; p0_we = 0; p0_addr = 16'h0010;
    p1_req = 1; p1_we = 0; p1_addr = 16'h0200;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("rr_acks", {p1_ack, p0_ack},
          (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("rr_idle", {gnt, p1_ack, p0_ack}, 4'b0000);
    end
    p0_req = 0; p1_req = 0;
    tick();

    // p1 owns the bus; p0 arrives during ACCESS
    p1_req = 1; p1_we = 0; p1_addr = 16'h0010;
    tick();
    chk("late_gnt1", gnt, 2'b10);
    p0_req = 1; p0_we = 0; p0_addr = 16'h0200;
    tick();
    p1_req = 0;
    chk("late_p1ack", p1_ack, 1'b1);
    chk("late_p1data", p1_rdata, 16'h8005);
    chk("late_p0ack", p0_ack, 1'b0);
    tick();
    chk("late_idle", gnt, 2'b00);
    tick();
    chk("late_gnt0", gnt, 2'b01);
    chk("late_addr", mem_addr, 16'h0200);
    tick();
    p0_req = 0;
    chk("late_p0ack2", p0_ack, 1'b1);
    chk("late_p0data", p0_rdata, 16'hBEEF);
    tick();

    // reset during ACCESS aborts, re-request completes
    p0_req = 1; p0_we = 0; p0_addr = 16'h0010;
    tick();
    chk("ab_en", mem_en, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_ack", p0_ack, 1'b0);
    chk("ab_outs", {mem_en, mem_we, gnt}, 4'b0000);
    chk("ab_addr", mem_addr, 16'h0000);
    chk("ab_rdata", p0_rdata, 16'h0000);
    tick();
    chk("ab_noack", p0_ack, 1'b0);
    chk("ab_reen", mem_en, 1'b1);
    tick();
    p0_req = 0;
    chk("ab_ack2", p0_ack, 1'b1);
    chk("ab_data2", p0_rdata, 16'h8005);
    tick();

    // address change during ACCESS is ignored
    p0_req = 1; p0_we = 0; p0_addr = 16'h0004;
    tick();
    p0_addr = 16'h0008;
    chk("lat_addr", mem_addr, 16'h0004);
    tick();
    p0_req = 0;
    chk("lat_addr2", mem_addr, 16'h0004);
    chk("lat_data", p0_rdata, 16'h1234);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
